// File: rtl/bus_scheduler_pkg.sv
// Shared state encoding and default sizing for the bus_scheduler block.
// A defs.svh pulled in ahead of this file may override `SIZE / `TRUE.
`ifndef SIZE
`define SIZE 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`endif

package bus_scheduler_pkg;

    localparam int DEF_USERS   = 4;
    localparam int DEF_WIDTH   = `SIZE;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/bus_scheduler.sv
// Round-robin scheduler sharing one four-phase asynchronous resource among
// USERS requesters; each grant runs a full req/ack cycle then returns a response.
module bus_scheduler
    import bus_scheduler_pkg::*;
#(
    parameter int USERS   = DEF_USERS,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [USERS-1:0]             user_valid,
    input  logic [USERS-1:0][WIDTH-1:0]  user_data,
    output logic [USERS-1:0]             user_ready,
    output logic [USERS-1:0]             resp_valid,
    input  logic [USERS-1:0]             resp_ready,
    output logic [WIDTH-1:0]             resp_data,
    output logic                         resp_err,
    output logic                         res_req,
    output logic [WIDTH-1:0]             res_in,
    input  logic                         res_ack,
    input  logic [WIDTH-1:0]             res_out,
    output logic                         err
);

    localparam int IDX_W = (USERS > 1) ? $clog2(USERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_req_q, res_req_d;
    logic [WIDTH-1:0]   res_in_q, res_in_d;
    logic [WIDTH-1:0]   resp_data_q, resp_data_d;
    logic               resp_err_q, resp_err_d;
    logic               err_q, err_d;
    logic               ack_s;
    logic [IDX_W-1:0]   grant_idx;

    sync2 u_ack_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (res_ack),
        .q     (ack_s)
    );

    // First requester after `last` in circular order; `last` itself is checked last.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [USERS-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= USERS; i++) begin
            idx = (int'(last) + i) % USERS;
            if (!found && req[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        res_in_d    = res_in_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        err_d       = err_q;
        user_ready  = '0;
        resp_valid  = '0;
        grant_idx   = rr_pick(user_valid, last_q);

        case (state_q)
            IDLE: begin
                // A lingering ack (late reply after a timeout) blocks new grants.
                if (!ack_s && (|user_valid)) begin
                    user_ready[grant_idx] = 1'b1;
                    res_in_d = user_data[grant_idx];
                    owner_d  = grant_idx;
                    cnt_d    = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_s) begin
                    resp_data_d = res_out;
                    resp_err_d  = 1'b0;
                    cnt_d       = '0;
                    state_d     = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_data_d = '0;
                    resp_err_d  = `TRUE;
                    err_d       = `TRUE;
                    state_d     = RESPOND;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    resp_data_d = '0;
                    resp_err_d  = `TRUE;
                    err_d       = `TRUE;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        res_req_d = (state_d == ISSUE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= IDX_W'(USERS - 1);
            cnt_q       <= '0;
            res_req_q   <= 1'b0;
            res_in_q    <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            res_req_q   <= res_req_d;
            res_in_q    <= res_in_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            err_q       <= err_d;
        end
    end

    assign res_req   = res_req_q;
    assign res_in    = res_in_q;
    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;
    assign err       = err_q;

endmodule

// File: doc/bus_scheduler.md
BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 SHALL have parameter USERS, default 4: number of requesters sharing one resource.
REQ-002 SHALL have parameter WIDTH, default `size: payload width.
REQ-003 SHALL have parameter TIMEOUT, default 255: cycles allowed per resource handshake phase.
REQ-004 SHALL have port clk  in  1  sole clock; all state on posedge clk.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port user_valid  in  USERS  per-user request pending.
REQ-007 SHALL have port user_data  in  USERS x WIDTH  per-user request payload.
REQ-008 SHALL have port user_ready  out  USERS  per-user accept strobe.
REQ-009 SHALL have port resp_valid  out  USERS  per-user response available.
REQ-010 SHALL have port resp_ready  in  USERS  per-user response consumed.
REQ-011 SHALL have port resp_data  out  WIDTH  response payload, shared by all users.
REQ-012 SHALL have port resp_err  out  1  response produced by timeout.
REQ-013 SHALL have port res_req  out  1  four-phase request to the async resource.
REQ-014 SHALL have port res_in  out  WIDTH  bundled payload to the resource.
REQ-015 SHALL have port res_ack  in  1  asynchronous four-phase acknowledge.
REQ-016 SHALL have port res_out  in  WIDTH  resource result, stable while res_ack=1.
REQ-017 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-018 SHALL pass res_ack through a 2-flop synchronizer (ack_s); ack_s is the only use of res_ack.
REQ-019 SHALL implement the FSM with states IDLE, ISSUE, RELEASE and RESPOND.
REQ-020 IDLE: when ack_s=0 and any user_valid=1, SHALL grant by round-robin, searching from (last_owner+1) mod USERS.
REQ-021 In IDLE, user_ready SHALL be combinational: one-hot on the granted user, zero otherwise. When valid&ready, it SHALL capture user_data into res_in and the owner index, then go to ISSUE.
REQ-022 SHALL make res_req a registered output that is 1 exactly while the state is ISSUE.
REQ-023 ISSUE: on ack_s=1, SHALL capture res_out into resp_data and go to RELEASE.
REQ-024 RELEASE: on ack_s=0, SHALL go to RESPOND.
REQ-025 RESPOND: SHALL assert resp_valid[owner] only. On resp_ready[owner], it SHALL set last_owner=owner and go to IDLE.
REQ-026 res_in, resp_data and resp_err SHALL remain stable from capture until the next capture.
REQ-027 With a zero-delay resource, resp_valid SHALL rise 7 cycles after the accept cycle. The chain is: accept in cycle 0; req high in cycle 1; ack_s=1 in cycle 3; req low in cycle 4; ack_s=0 in cycle 6; RESPOND in cycle 7.
REQ-028 A phase counter SHALL clear on entry to ISSUE and on entry to RELEASE, and SHALL saturate.
REQ-029 Timeout in ISSUE or RELEASE (count reaches TIMEOUT) SHALL go to RESPOND with resp_err=1, resp_data=0 and err set.
REQ-030 A non-timeout response SHALL carry resp_err=0.
REQ-031 If ack_s=1 in IDLE (a late ack after a timeout), the block SHALL not grant until ack_s=0; no other action.
REQ-032 Requests arriving during ISSUE/RELEASE/RESPOND SHALL wait; user_ready SHALL be 0 outside IDLE.
REQ-033 A user deasserting user_valid before ready SHALL lose nothing and SHALL not be granted.
REQ-034 With a single requester, round-robin SHALL re-grant it back-to-back.

Reset
REQ-035 Reset SHALL put the FSM in IDLE and set last_owner=USERS-1, so user 0 is first.
REQ-036 Reset SHALL clear res_req, res_in, resp_data, resp_err, err, the counter and both synchronizer flops.
REQ-037 reset_n assertion mid-handshake SHALL drop res_req immediately. After release, the block SHALL not grant until ack_s=0.

Structure
REQ-038 The shared package SHALL hold the state enum typedef and the default USERS/WIDTH/TIMEOUT constants; `size and `true come from defs.svh.
REQ-039 The block SHALL instantiate one sub-module, sync2 (2-flop synchronizer, async active-low reset).
REQ-040 The round-robin pick SHALL be a function in bus_scheduler, not a separate module.

Verification
REQ-041 Zero-delay resource, user 2 sends 0x5A:
  - res_in=0x5A;
  - resp_valid[2] rises at accept+7 with resp_data=res_out and resp_err=0.
REQ-042 All 4 users valid continuously, resp_ready=1:
  - grant order is 0,1,2,3,0;
  - user_ready is never multi-hot.
REQ-043 res_ack tied 0, TIMEOUT=8:
  - res_req falls after 8 ISSUE cycles;
  - resp_err=1, resp_data=0, err=1 stays until reset.
REQ-044 res_ack rises 20 cycles after the timeout:
  - no grant while ack_s=1;
  - next request is accepted only after res_ack returns 0.
REQ-045 reset_n pulsed low while in ISSUE:
  - res_req goes to 0 asynchronously;
  - all outputs are at reset values;
  - user 0 is granted first afterwards.
REQ-046 resp_ready held 0 for 10 cycles in RESPOND:
  - resp_valid and resp_data are held;
  - other users see user_ready=0.
